// File: rtl/scarv_cop_mem_resp_pkg.sv
// Shared constants for the COP memory responder: FSM encodings and LFSR settings.
// The LFSR constants are only referenced when SCARV_COP_MEM_RESP_RAND_STALL_EN is defined.
package scarv_cop_mem_resp_pkg;

  localparam logic [1:0]  SCARV_COP_MRESP_IDLE = 2'd0;
  localparam logic [1:0]  SCARV_COP_MRESP_WAIT = 2'd1;
  localparam logic [1:0]  SCARV_COP_MRESP_RESP = 2'd2;

  localparam logic [15:0] SCARV_COP_MRESP_LFSR_SEED = 16'hACE1;
  // Galois mask for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form
  localparam logic [15:0] SCARV_COP_MRESP_LFSR_TAPS = 16'hB400;
  localparam logic [1:0]  SCARV_COP_MRESP_MAX_EXTRA = 2'd3;

endpackage

// File: rtl/scarv_cop_mem_resp_lfsr.sv
// 16-bit Galois LFSR with step enable; supplies the random-stall bit to the responder.
// Only instantiated when SCARV_COP_MEM_RESP_RAND_STALL_EN is defined.
module scarv_cop_mem_resp_lfsr
  import scarv_cop_mem_resp_pkg::*;
(
  input  logic g_clk,
  input  logic g_resetn,
  input  logic step_en,
  output logic rnd_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (step_en) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? SCARV_COP_MRESP_LFSR_TAPS : 16'h0000);
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      lfsr_q <= SCARV_COP_MRESP_LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rnd_o = lfsr_q[0];

endmodule

// File: rtl/scarv_cop_mem_resp.sv
// Memory responder for the COP load/store bus: word array with fixed wait states and
// back-to-back acceptance. Define SCARV_COP_MEM_RESP_RAND_STALL_EN for LFSR-driven extra stalls.
module scarv_cop_mem_resp
  import scarv_cop_mem_resp_pkg::*;
#(
  parameter int unsigned MEM_DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE       = 32'h0001_0000,
  parameter int unsigned WAIT_CYCLES     = 0
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        cop_mem_cen,
  input  logic        cop_mem_wen,
  input  logic [31:0] cop_mem_addr,
  input  logic [31:0] cop_mem_wdata,
  input  logic [3:0]  cop_mem_ben,
  output logic [31:0] cop_mem_rdata,
  output logic        cop_mem_stall,
  output logic        cop_mem_error
);

  localparam int unsigned IDX_W     = $clog2(MEM_DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [32:0] ADDR_END  = {1'b0, ADDR_BASE} + 33'(4 * MEM_DEPTH_WORDS);

  logic [1:0]  state_q,    state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] addr_q,     addr_d;
  logic        wen_q,      wen_d;
  logic [31:0] wdata_q,    wdata_d;
  logic [3:0]  ben_q,      ben_d;

  logic [31:0] mem_q [MEM_DEPTH_WORDS];

  logic             accept;
  logic             err;
  logic [IDX_W-1:0] idx;
  logic             in_resp;
  logic             wr_commit;

`ifdef SCARV_COP_MEM_RESP_RAND_STALL_EN
  logic [1:0] extra_cnt_q, extra_cnt_d;
  logic [1:0] extra_base;
  logic       rnd;

  scarv_cop_mem_resp_lfsr u_lfsr (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .step_en  (1'b1),
    .rnd_o    (rnd)
  );
`endif

  // Base is aligned to the array size, so the word index is a plain slice of the address.
  assign idx       = addr_q[IDX_W+1:2];
  assign err       = (addr_q < ADDR_BASE) || ({1'b0, addr_q} >= ADDR_END) ||
                     (addr_q[1:0] != 2'b00);
  assign in_resp   = (state_q == SCARV_COP_MRESP_RESP);
  assign wr_commit = in_resp && wen_q && !err;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    ben_d      = ben_q;
    accept     = 1'b0;
    case (state_q)
      SCARV_COP_MRESP_IDLE, SCARV_COP_MRESP_RESP: begin
        if (cop_mem_cen) begin
          accept     = 1'b1;
          addr_d     = cop_mem_addr;
          wen_d      = cop_mem_wen;
          wdata_d    = cop_mem_wdata;
          ben_d      = cop_mem_ben;
          wait_cnt_d = WAIT_INIT;
          state_d    = (WAIT_CYCLES > 0) ? SCARV_COP_MRESP_WAIT : SCARV_COP_MRESP_RESP;
        end else begin
          state_d = SCARV_COP_MRESP_IDLE;
        end
      end
      SCARV_COP_MRESP_WAIT: begin
        wait_cnt_d = (wait_cnt_q > 4'd1) ? wait_cnt_q - 4'd1 : 4'd0;
        if (wait_cnt_q <= 4'd1) begin
          state_d = SCARV_COP_MRESP_RESP;
        end
      end
      default: state_d = SCARV_COP_MRESP_IDLE;
    endcase
`ifdef SCARV_COP_MEM_RESP_RAND_STALL_EN
    // Any transition into RESP may be deferred; a zero wait count keeps WAIT ready to exit.
    extra_base  = accept ? 2'd0 : extra_cnt_q;
    extra_cnt_d = extra_base;
    if ((state_d == SCARV_COP_MRESP_RESP) && rnd && (extra_base < SCARV_COP_MRESP_MAX_EXTRA)) begin
      state_d     = SCARV_COP_MRESP_WAIT;
      wait_cnt_d  = 4'd0;
      extra_cnt_d = extra_base + 2'd1;
    end
`endif
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q    <= SCARV_COP_MRESP_IDLE;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      ben_q      <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      ben_q      <= ben_d;
    end
  end

`ifdef SCARV_COP_MEM_RESP_RAND_STALL_EN
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      extra_cnt_q <= '0;
    end else begin
      extra_cnt_q <= extra_cnt_d;
    end
  end
`endif

  always_ff @(posedge g_clk) begin
    if (wr_commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (ben_q[i]) begin
          mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign cop_mem_stall = (state_q == SCARV_COP_MRESP_WAIT);
  assign cop_mem_error = in_resp && err;
  assign cop_mem_rdata = (in_resp && !err && !wen_q) ? mem_q[idx] : 32'h0000_0000;

endmodule

// File: tb/tb_scarv_cop_mem_resp.sv
// Directed bench for scarv_cop_mem_resp: one zero-wait instance and one three-wait instance.
module tb_scarv_cop_mem_resp;

  logic        clk;
  logic        rstn0, cen0, wen0, stall0, err0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [3:0]  ben0;
  logic        rstn3, cen3, wen3, stall3, err3;
  logic [31:0] addr3, wdata3, rdata3;
  logic [3:0]  ben3;

  int checks   = 0;
  int failures = 0;

  scarv_cop_mem_resp #(.WAIT_CYCLES(0)) dut0 (
    .g_clk(clk), .g_resetn(rstn0), .cop_mem_cen(cen0), .cop_mem_wen(wen0),
    .cop_mem_addr(addr0), .cop_mem_wdata(wdata0), .cop_mem_ben(ben0),
    .cop_mem_rdata(rdata0), .cop_mem_stall(stall0), .cop_mem_error(err0)
  );

  scarv_cop_mem_resp #(.WAIT_CYCLES(3)) dut3 (
    .g_clk(clk), .g_resetn(rstn3), .cop_mem_cen(cen3), .cop_mem_wen(wen3),
    .cop_mem_addr(addr3), .cop_mem_wdata(wdata3), .cop_mem_ben(ben3),
    .cop_mem_rdata(rdata3), .cop_mem_stall(stall3), .cop_mem_error(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Drive one request on the zero-wait instance; returns #1 after the accepting edge.
  task automatic tx0(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    cen0 = 1'b1; wen0 = w; addr0 = a; wdata0 = d; ben0 = b;
    @(posedge clk); #1;
  endtask

  task automatic idle0();
    cen0 = 1'b0; wen0 = 1'b0; addr0 = '0; wdata0 = '0; ben0 = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn0 = 1'b0; rstn3 = 1'b0;
    cen0 = 1'b0; wen0 = 1'b0; addr0 = '0; wdata0 = '0; ben0 = '0;
    cen3 = 1'b0; wen3 = 1'b0; addr3 = '0; wdata3 = '0; ben3 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (stall0 !== 1'b0) begin failures++; $display("FAIL reset_stall0 got=%b exp=0", stall0); end
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL reset_err0 got=%b exp=0", err0); end
    checks++; if (rdata0 !== 32'h0) begin failures++; $display("FAIL reset_rdata0 got=%h exp=0", rdata0); end
    checks++; if (stall3 !== 1'b0) begin failures++; $display("FAIL reset_stall3 got=%b exp=0", stall3); end
    checks++; if (rdata3 !== 32'h0) begin failures++; $display("FAIL reset_rdata3 got=%h exp=0", rdata3); end
    rstn0 = 1'b1; rstn3 = 1'b1;
  endtask

  task automatic test_rw_zero_wait();
    tx0(1'b1, 32'h0001_0004, 32'hDEAD_BEEF, 4'b1111);
    checks++; if (stall0 !== 1'b0) begin failures++; $display("FAIL rw_wr_stall got=%b exp=0", stall0); end
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL rw_wr_err got=%b exp=0", err0); end
    tx0(1'b0, 32'h0001_0004, 32'h0, 4'b0000);
    checks++; if (stall0 !== 1'b0) begin failures++; $display("FAIL rw_rd_stall got=%b exp=0", stall0); end
    checks++; if (rdata0 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rw_rd_data got=%h exp=deadbeef", rdata0); end
    idle0();
    checks++; if (stall0 !== 1'b0) begin failures++; $display("FAIL rw_idle_stall got=%b exp=0", stall0); end
    checks++; if (rdata0 !== 32'h0) begin failures++; $display("FAIL rw_idle_rdata got=%h exp=0", rdata0); end
  endtask

  task automatic test_byte_lanes();
    tx0(1'b1, 32'h0001_0008, 32'h1122_3344, 4'b1111);
    tx0(1'b1, 32'h0001_0008, 32'h00AA_0000, 4'b0100);
    tx0(1'b0, 32'h0001_0008, 32'h0, 4'b0000);
    checks++; if (rdata0 !== 32'h11AA_3344) begin failures++; $display("FAIL lanes_rdata got=%h exp=11aa3344", rdata0); end
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL lanes_err got=%b exp=0", err0); end
    idle0();
  endtask

  task automatic test_errors();
    tx0(1'b0, 32'h0000_FFFC, 32'h0, 4'b0000);
    checks++; if (err0 !== 1'b1) begin failures++; $display("FAIL err_below_err got=%b exp=1", err0); end
    checks++; if (rdata0 !== 32'h0) begin failures++; $display("FAIL err_below_rdata got=%h exp=0", rdata0); end
    tx0(1'b1, 32'h0001_0000, 32'h5566_7788, 4'b1111);
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL err_base_wr got=%b exp=0", err0); end
    tx0(1'b1, 32'h0001_0002, 32'hFFFF_FFFF, 4'b1111);
    checks++; if (err0 !== 1'b1) begin failures++; $display("FAIL err_misalign_err got=%b exp=1", err0); end
    tx0(1'b1, 32'h0001_0FFC, 32'h0BAD_F00D, 4'b1111);
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL err_last_wr got=%b exp=0", err0); end
    tx0(1'b0, 32'h0001_1000, 32'h0, 4'b0000);
    checks++; if (err0 !== 1'b1) begin failures++; $display("FAIL err_end_err got=%b exp=1", err0); end
    checks++; if (rdata0 !== 32'h0) begin failures++; $display("FAIL err_end_rdata got=%h exp=0", rdata0); end
    tx0(1'b0, 32'h0001_0FFC, 32'h0, 4'b0000);
    checks++; if (rdata0 !== 32'h0BAD_F00D) begin failures++; $display("FAIL err_last_rdata got=%h exp=0badf00d", rdata0); end
    tx0(1'b0, 32'h0001_0000, 32'h0, 4'b0000);
    checks++; if (rdata0 !== 32'h5566_7788) begin failures++; $display("FAIL err_misalign_kept got=%h exp=55667788", rdata0); end
    idle0();
  endtask

  task automatic test_back_to_back();
    logic [31:0] lane_data [4];
    logic [3:0]  lane_ben  [4];
    lane_data[0] = 32'h0000_00A1; lane_ben[0] = 4'b0001;
    lane_data[1] = 32'h0000_B200; lane_ben[1] = 4'b0010;
    lane_data[2] = 32'h00C3_0000; lane_ben[2] = 4'b0100;
    lane_data[3] = 32'hD400_0000; lane_ben[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      tx0(1'b1, 32'h0001_0010, lane_data[i], lane_ben[i]);
      checks++; if (stall0 !== 1'b0 || err0 !== 1'b0) begin
        failures++; $display("FAIL scatter_retire[%0d] stall=%b err=%b exp stall=0 err=0", i, stall0, err0);
      end
    end
    tx0(1'b0, 32'h0001_0010, 32'h0, 4'b0000);
    checks++; if (rdata0 !== 32'hD4C3_B2A1) begin failures++; $display("FAIL scatter_word got=%h exp=d4c3b2a1", rdata0); end
    idle0();
  endtask

  task automatic test_wait3();
    cen3 = 1'b1; wen3 = 1'b1; addr3 = 32'h0001_0000; wdata3 = 32'hCAFE_F00D; ben3 = 4'b1111;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (stall3 !== 1'b1) begin failures++; $display("FAIL w3_wr_stall[%0d] got=%b exp=1", i, stall3); end
      @(posedge clk); #1;
    end
    checks++; if (stall3 !== 1'b0) begin failures++; $display("FAIL w3_wr_done got=%b exp=0", stall3); end
    wen3 = 1'b0; wdata3 = '0; ben3 = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (stall3 !== 1'b1 || rdata3 !== 32'h0) begin
        failures++; $display("FAIL w3_rd_stall[%0d] stall=%b rdata=%h exp stall=1 rdata=0", i, stall3, rdata3);
      end
      @(posedge clk); #1;
    end
    checks++; if (stall3 !== 1'b0) begin failures++; $display("FAIL w3_rd_done got=%b exp=0", stall3); end
    checks++; if (rdata3 !== 32'hCAFE_F00D) begin failures++; $display("FAIL w3_rd_data got=%h exp=cafef00d", rdata3); end
    cen3 = 1'b0;
    @(posedge clk); #1;
    checks++; if (stall3 !== 1'b0 || rdata3 !== 32'h0) begin
      failures++; $display("FAIL w3_idle stall=%b rdata=%h exp stall=0 rdata=0", stall3, rdata3);
    end
  endtask

  task automatic test_reset_mid_wait();
    cen3 = 1'b1; wen3 = 1'b1; addr3 = 32'h0001_0020; wdata3 = 32'h1234_5678; ben3 = 4'b1111;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (stall3 !== 1'b0) begin failures++; $display("FAIL rst_pre_done got=%b exp=0", stall3); end
    cen3 = 1'b0;
    @(posedge clk); #1;
    cen3 = 1'b1; wen3 = 1'b1; addr3 = 32'h0001_0020; wdata3 = 32'hFFFF_FFFF; ben3 = 4'b1111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (stall3 !== 1'b1) begin failures++; $display("FAIL rst_midwait_stall got=%b exp=1", stall3); end
    rstn3 = 1'b0; cen3 = 1'b0;
    #1;
    checks++; if (stall3 !== 1'b0 || err3 !== 1'b0 || rdata3 !== 32'h0) begin
      failures++; $display("FAIL rst_async_outs stall=%b err=%b rdata=%h exp all 0", stall3, err3, rdata3);
    end
    @(posedge clk); #1;
    rstn3 = 1'b1;
    @(posedge clk); #1;
    checks++; if (stall3 !== 1'b0) begin failures++; $display("FAIL rst_idle_stall got=%b exp=0", stall3); end
    cen3 = 1'b1; wen3 = 1'b0; addr3 = 32'h0001_0020; wdata3 = '0; ben3 = '0;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rdata3 !== 32'h1234_5678) begin failures++; $display("FAIL rst_mem_kept got=%h exp=12345678", rdata3); end
    cen3 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_rw_zero_wait();
    test_byte_lanes();
    test_errors();
    test_back_to_back();
    test_wait3();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scarv_cop_mem_resp.md
Name: scarv_cop_mem_resp

Overview:
- Memory responder (slave) end of the coprocessor load/store bus (cop_mem_*).
- Backs an on-chip word array; returns read data, stall and error to the COP memory unit.
- Used as the memory behind the COP in the integration testbench and FPGA builds.
- Supports configurable fixed wait states and back-to-back transactions, so scatter/gather sequences complete in consecutive cycles.

Parameters:
- MEM_DEPTH_WORDS, 1024: number of 32-bit words; power of two, at least 4.
- ADDR_BASE, 32'h0001_0000: byte address of word 0; must be aligned to 4*MEM_DEPTH_WORDS.
- WAIT_CYCLES, 0: stall cycles inserted before each response; legal range 0..15.

Ports:
- g_clk  in  1  global clock.
- g_resetn  in  1  asynchronous active-low reset.
- cop_mem_cen  in  1  request valid.
- cop_mem_wen  in  1  1 = write, 0 = read.
- cop_mem_addr  in  32  byte address; initiator sends it word aligned.
- cop_mem_wdata  in  32  write data, already lane-shifted by the initiator.
- cop_mem_ben  in  4  write byte enables; bit i maps to wdata[8i+7:8i].
- cop_mem_rdata  out  32  read data; valid only in a completion cycle.
- cop_mem_stall  out  1  response not yet available.
- cop_mem_error  out  1  bus error; valid only in a completion cycle.

Behaviour:
- States: IDLE (no outstanding request), WAIT (counting down wait states), RESP (completion cycle).
- Accept:
  - A request is accepted at a rising edge when cen=1 and the state is IDLE or RESP.
  - On accept, register addr, wen, wdata, ben; load wait_cnt = WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - stall=1.
  - wait_cnt decrements each cycle; go to RESP when wait_cnt==1.
  - cen is ignored in WAIT; the initiator holds the same request while stalled, and it must not be re-accepted.
- RESP:
  - stall=0; error and rdata are driven for the registered request.
  - Latency from accept edge to completion cycle is exactly WAIT_CYCLES+1 cycles.
- Back-to-back: if cen=1 during RESP, the new request is accepted at the same edge that retires the current one. No idle bubble.
- RESP exit: with cen=0, go to IDLE.
- Error check: error=1 if the registered address is below ADDR_BASE, at or above ADDR_BASE+4*MEM_DEPTH_WORDS, or has addr[1:0]!=0. Index = (addr-ADDR_BASE)>>2, width clog2(MEM_DEPTH_WORDS).
- Reads: rdata = mem[index] in RESP. rdata=0 in every non-RESP cycle and on error.
- Writes:
  - Committed at the rising edge ending the RESP cycle.
  - Only lanes with ben[i]=1 are written; ben=0000 writes nothing but still completes.
  - Errored writes never modify memory.
- Read-after-write: a read accepted in the same cycle a write retires sees the new data. No forwarding is needed because the read samples memory in its own RESP cycle, which is later.
- IDLE outputs: stall=0, error=0, rdata=0.
- Reset:
  - Asynchronous assertion forces state=IDLE, wait_cnt=0, all registered request fields to 0, and all outputs to 0. Memory contents are not reset.
  - Reset mid-WAIT or mid-RESP drops the transaction; a pending write is not committed.
- Reset release: the first accept is possible at the first rising edge after g_resetn deasserts.

Optional Feature:
- Macro: SCARV_COP_MEM_RESP_RAND_STALL_EN.
- Defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1; async reset to seed) steps every cycle.
  - When the block would otherwise enter RESP and lfsr[0]=1, it stays in WAIT one more cycle.
  - At most 3 consecutive extra stall cycles per transaction; an extra-stall counter resets on accept.
  - The total latency bound is WAIT_CYCLES+4.
- Undefined: latency is exactly WAIT_CYCLES+1; no LFSR logic is present.

Decomposition:
- Into scarv_cop_common.vh:
  - state encodings SCARV_COP_MRESP_IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
  - the LFSR seed and max-extra-stall constant (3).
- Optional sub-module scarv_cop_mem_resp_lfsr (16-bit LFSR with step enable), instantiated only under the macro.
- The memory array stays inline.

Test Plan:
- WAIT_CYCLES=0:
  - write 32'hDEADBEEF to 0x00010004 with ben=1111, then read the same address back-to-back;
  - stall stays 0 throughout and rdata=32'hDEADBEEF in the cycle after the read is accepted.
- Byte lanes: preload 0x00010008=32'h11223344, write wdata=32'h00AA0000 with ben=0100, read -> 32'h11AA3344.
- WAIT_CYCLES=3 read of 0x00010000:
  - stall=1 for exactly 3 cycles, then 1 completion cycle with stall=0 and valid rdata;
  - cen is held high throughout and causes no duplicate accept.
- Errors:
  - read 0x0000FFFC (below base) -> error=1, rdata=0;
  - write 0x00010002 (misaligned) -> error=1 and the target word is unchanged.
- Scatter pattern: 4 consecutive byte writes to 0x00010010..13 (ben 0001,0010,0100,1000) issued on consecutive completion cycles -> one transaction retires per cycle, and the final word equals the 4 assembled bytes.
- Reset: assert g_resetn low mid-WAIT of a write -> outputs go to 0 immediately, state is IDLE, and memory is unchanged after release.
